// File: rtl/program_loader_pkg.sv
// Shared constants and loader state encoding for the program-memory loader.
// These values match the ones used by the microcontroller core and PMem.
package program_loader_pkg;
  localparam int PMEM_DEPTH = 10;
  localparam int ADDR_W     = 8;
  localparam int INSTR_W    = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_WR   = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

  // A count is legal only if it is in the range 1..PMEM_DEPTH.
  function automatic logic cnt_ok(input logic [7:0] n);
    return (n != 8'd0) && (n <= 8'(PMEM_DEPTH));
  endfunction
endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, PMem load port and status flags of the loader.
interface program_loader_if;
  import program_loader_pkg::*;

  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               load_we;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_instr;
  logic               load_done;
  logic               load_err;
  logic               busy;

  modport slave (
    input  in_valid, in_data,
    output in_ready, load_we, load_addr, load_instr, load_done, load_err, busy
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, load_we, load_addr, load_instr, load_done, load_err, busy
  );
endinterface

// File: rtl/program_loader_instr_assembler.sv
// Captures the LO byte, checks the HI nibble and keeps the running XOR checksum.
module program_loader_instr_assembler
  import program_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cnt_take_i,
  input  logic               lo_take_i,
  input  logic               hi_take_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               hi_bad_o,
  output logic [7:0]         chk_o
);
  logic [7:0] lo_q, lo_d;
  logic [7:0] chk_q, chk_d;

  assign hi_bad_o = (byte_i[7:4] != 4'd0);
  // The word is formed from the HI byte still on the bus, so it is valid during the HI accept.
  assign word_o   = {byte_i[3:0], lo_q};
  assign chk_o    = chk_q;

  always_comb begin
    lo_d  = lo_q;
    chk_d = chk_q;
    if (cnt_take_i) begin
      chk_d = byte_i;
    end else if (lo_take_i) begin
      lo_d  = byte_i;
      chk_d = chk_q ^ byte_i;
    end else if (hi_take_i && !hi_bad_o) begin
      chk_d = chk_q ^ byte_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lo_q  <= '0;
      chk_q <= '0;
    end else begin
      lo_q  <= lo_d;
      chk_q <= chk_d;
    end
  end
endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: count, LO/HI instruction bytes, XOR checksum.
// Writes one 12-bit word per load_we strobe and flags done or error.
module program_loader
  import program_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  program_loader_if.slave  lif
);
  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]  load_addr_q, load_addr_d;
  logic [INSTR_W-1:0] load_instr_q, load_instr_d;

  logic               take, cnt_take, lo_take, hi_take, hi_bad, last_word;
  logic [INSTR_W-1:0] word;
  logic [7:0]         chk;

  assign take      = lif.in_valid && lif.in_ready;
  assign cnt_take  = take && (state_q == ST_IDLE) && cnt_ok(lif.in_data);
  assign lo_take   = take && (state_q == ST_LO);
  assign hi_take   = take && (state_q == ST_HI);
  assign last_word = (wr_addr_q == ADDR_W'(cnt_q - 8'd1));

  program_loader_instr_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .cnt_take_i (cnt_take),
    .lo_take_i  (lo_take),
    .hi_take_i  (hi_take),
    .byte_i     (lif.in_data),
    .word_o     (word),
    .hi_bad_o   (hi_bad),
    .chk_o      (chk)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wr_addr_q    <= '0;
      load_addr_q  <= '0;
      load_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_addr_q    <= wr_addr_d;
      load_addr_q  <= load_addr_d;
      load_instr_q <= load_instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_addr_d    = wr_addr_q;
    load_addr_d  = load_addr_q;
    load_instr_d = load_instr_q;
    case (state_q)
      ST_IDLE: if (take) begin
        if (cnt_take) begin
          cnt_d     = lif.in_data;
          wr_addr_d = '0;
          state_d   = ST_LO;
        end else begin
          state_d   = ST_ERR;
        end
      end
      ST_LO:   if (take) state_d = ST_HI;
      // Write port values are latched here so they stay put after the strobe.
      ST_HI:   if (take) begin
        if (hi_bad) begin
          state_d      = ST_ERR;
        end else begin
          load_addr_d  = wr_addr_q;
          load_instr_d = word;
          state_d      = ST_WR;
        end
      end
      ST_WR: begin
        wr_addr_d = wr_addr_q + 1'b1;
        state_d   = last_word ? ST_CHK : ST_LO;
      end
      ST_CHK:  if (take) state_d = (lif.in_data == chk) ? ST_DONE : ST_ERR;
      ST_DONE, ST_ERR: if (restart) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lif.in_ready  = rst && ((state_q == ST_IDLE) || (state_q == ST_LO) ||
                            (state_q == ST_HI)   || (state_q == ST_CHK));
    lif.load_we   = (state_q == ST_WR);
    lif.busy      = (state_q == ST_LO) || (state_q == ST_HI) ||
                    (state_q == ST_WR) || (state_q == ST_CHK);
    lif.load_done = (state_q == ST_DONE);
    lif.load_err  = (state_q == ST_ERR);
    lif.load_addr  = load_addr_q;
    lif.load_instr = load_instr_q;
  end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/gapped loads, checksum, count, HI-nibble and reset cases.
module tb_program_loader;
  import program_loader_pkg::*;

  typedef logic [7:0]  bq_t[$];
  typedef logic [19:0] wq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic restart = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  wq_t  wr_log;

  always #5 clk = ~clk;

  program_loader_if lif();

  program_loader dut (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .lif     (lif)
  );

  // One log entry per cycle with load_we high, so a stretched strobe shows up as a duplicate.
  always @(negedge clk) if (rst && lif.load_we) wr_log.push_back({lif.load_addr, lif.load_instr});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int budget = 0;
    repeat (gap) begin
      @(negedge clk);
      lif.in_valid = 1'b0;
    end
    @(negedge clk);
    lif.in_valid = 1'b1;
    lif.in_data  = b;
    while (!lif.in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) check("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    lif.in_valid = 1'b0;
  endtask

  task automatic send_stream(input bq_t s, input int maxgap);
    for (int i = 0; i < s.size(); i++) send(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    idle();
  endtask

  task automatic check_writes(input string tag, input wq_t exp);
    check({tag, "_nwr"}, wr_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wr_log.size(); i++) check({tag, "_wr"}, wr_log[i], exp[i]);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_done", lif.load_done, 1'b0);
    check("restart_err",  lif.load_err,  1'b0);
    check("restart_rdy",  lif.in_ready,  1'b1);
    wr_log.delete();
  endtask

  initial begin
    bq_t good, s;
    wq_t w;

    // Reset held with in_valid high
    lif.in_valid = 1'b1;
    lif.in_data  = 8'h02;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", lif.in_ready,   1'b0);
    check("rst_we",    lif.load_we,    1'b0);
    check("rst_done",  lif.load_done,  1'b0);
    check("rst_err",   lif.load_err,   1'b0);
    check("rst_busy",  lif.busy,       1'b0);
    check("rst_addr",  lif.load_addr,  32'h0);
    check("rst_instr", lif.load_instr, 32'h0);
    lif.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", lif.in_ready, 1'b1);

    // Good load, first word strobe timing checked by hand
    good = '{8'h02, 8'h34, 8'h01, 8'h78, 8'h0A, 8'h45};
    w    = '{20'h00134, 20'h01A78};
    send(8'h02, 0); send(8'h34, 0); send(8'h01, 0);
    @(negedge clk);
    lif.in_valid = 1'b0;
    check("wr0_we",    lif.load_we,    1'b1);
    check("wr0_addr",  lif.load_addr,  32'h0);
    check("wr0_instr", lif.load_instr, 32'h134);
    @(negedge clk);
    check("wr0_we_off", lif.load_we, 1'b0);
    check("mid_busy",   lif.busy,    1'b1);
    send(8'h78, 0); send(8'h0A, 0); send(8'h45, 0);
    idle();
    check("good_done",  lif.load_done,  1'b1);
    check("good_err",   lif.load_err,   1'b0);
    check("good_busy",  lif.busy,       1'b0);
    check("good_rdy",   lif.in_ready,   1'b0);
    check("hold_addr",  lif.load_addr,  32'h1);
    check("hold_instr", lif.load_instr, 32'hA78);
    check_writes("good", w);
    do_restart();

    // Same stream with random in_valid gaps
    send_stream(good, 3);
    check("gap_done", lif.load_done, 1'b1);
    check("gap_err",  lif.load_err,  1'b0);
    check_writes("gap", w);
    do_restart();

    // Bad checksum, then recovery
    s = '{8'h02, 8'h34, 8'h01, 8'h78, 8'h0A, 8'h44};
    send_stream(s, 0);
    check("badchk_err",  lif.load_err,  1'b1);
    check("badchk_done", lif.load_done, 1'b0);
    check_writes("badchk", w);
    do_restart();
    send_stream(good, 1);
    check("recover_done", lif.load_done, 1'b1);
    check_writes("recover", w);
    do_restart();

    // Count bounds
    s = '{8'h00};
    send_stream(s, 0);
    check("n00_err", lif.load_err, 1'b1);
    check_writes("n00", '{});
    do_restart();
    s = '{8'h0B};
    send_stream(s, 0);
    check("n0b_err", lif.load_err, 1'b1);
    check_writes("n0b", '{});
    do_restart();

    // Full depth: word i = {i, 0x10+i}; checksum 0A ^ 01 ^ 01 = 0A
    s = '{8'h0A};
    w = '{};
    for (int i = 0; i < 10; i++) begin
      s.push_back(8'h10 + 8'(i));
      s.push_back(8'(i));
      w.push_back({8'(i), 4'(i), 8'h10 + 8'(i)});
    end
    s.push_back(8'h0A);
    send_stream(s, 0);
    check("n0a_done", lif.load_done, 1'b1);
    check("n0a_err",  lif.load_err,  1'b0);
    check_writes("n0a", w);
    do_restart();

    // Bad HI nibble
    s = '{8'h01, 8'h34, 8'h1F};
    send_stream(s, 0);
    check("badhi_err", lif.load_err, 1'b1);
    check_writes("badhi", '{});
    do_restart();

    // Reset after the first write of a 3-word load
    send(8'h03, 0); send(8'h11, 0); send(8'h02, 0); send(8'h22, 0);
    @(negedge clk);
    lif.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_we",    lif.load_we,    1'b0);
    check("mrst_addr",  lif.load_addr,  32'h0);
    check("mrst_instr", lif.load_instr, 32'h0);
    check("mrst_busy",  lif.busy,       1'b0);
    check("mrst_rdy",   lif.in_ready,   1'b0);
    check("mrst_err",   lif.load_err,   1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("mrst_rdy_after", lif.in_ready, 1'b1);
    check("mrst_busy_after", lif.busy,    1'b0);
    check_writes("mrst", '{20'h00211});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end
endmodule
